ex_stage_md: RTL and testbench
==============================

Name: ex_stage_md

Overview:
- Registered, multi-cycle execute stage: operand forwarding muxes and single-cycle ALU path, plus an iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits between the ID/EX register and the MEM stage and absorbs the EX/MEM pipeline register.
- Raises busy to the hazard unit while a mul/div iterates, which stalls IF/ID.

Parameters:
WORD_SIZE, 32, datapath width; must be even and >= 8
NUM_REGS, 32, register count
REG_SEL, $clog2(NUM_REGS), register index width
ADDR_SIZE, 10, PC / branch target width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  ID/EX holds a valid instruction
flush  in  1  kill the in-flight instruction and the input instruction
pc  in  ADDR_SIZE  PC of the next instruction
data1, wb_forward1, mem_forward1  in  WORD_SIZE each  rs1 candidates
data2, wb_forward2, mem_forward2  in  WORD_SIZE each  rs2 candidates
sel_forward1, sel_forward2  in  2 each  forwarding select
immd  in  WORD_SIZE  immediate
alu_op  in  4  ALU operation, existing alu encoding
alu_src  in  1  0 = rs2, 1 = immd
md_en  in  1  instruction is an RV32M op
md_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rd  in  REG_SEL  destination register
data_size  in  2  memory access size
data_sign  in  1  memory access sign
busy  out  1  stage cannot accept; stall upstream
out_valid  out  1  outputs hold a completed instruction
result  out  WORD_SIZE  ALU or mul/div result, also the memory address
save_data  out  WORD_SIZE  forwarded rs2 value
zero  out  1  result == 0
branch_target  out  ADDR_SIZE  pc + (immd << 2), truncated to ADDR_SIZE
rd_out  out  REG_SEL  registered rd
data_size_out  out  2  registered data_size
data_sign_out  out  1  registered data_sign

Behaviour:
- Forward select encoding:
  - 0 = dataN
  - 1 = mem_forwardN
  - 2 = wb_forwardN
  - 3 = dataN
- The ALU consumes the forwarded values, never the raw dataN.
- Accept condition: in_valid && !busy && !flush.
- Reset (and flush): state IDLE; every output is 0, including busy and out_valid.
- FSM states: IDLE, ITER, FIX.
- IDLE, accept with md_en=0:
  - At the next edge, register the ALU result, zero, save_data, branch_target, rd, data_size and data_sign.
  - out_valid=1 for one cycle (latency 1).
- IDLE, accept with md_en=1:
  - Capture the forwarded operands (alu_src is ignored; rs2 is always used), the absolute values, sign flags, md_op, rd and the sideband signals.
  - Go to ITER, counter=0. busy=1 from the next cycle.
  - The forwarding inputs may change freely after capture.
- ITER: one bit per cycle for WORD_SIZE cycles.
  - Multiply: shift-add on unsigned magnitudes into a 2*WORD_SIZE product.
  - Divide: restoring division.
  - At counter == WORD_SIZE-1, go to FIX.
- FIX: apply sign correction and select the result.
  - MUL: low half.
  - MULH/MULHSU/MULHU: high half of signed*signed, signed*unsigned, unsigned*unsigned.
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
  - DIV: quotient sign = sign1 XOR sign2. REM: remainder takes the sign of the dividend.
  - The special cases still take full latency.
  - Next edge: outputs registered, out_valid=1, busy=0, state IDLE.
- Total mul/div latency: accept at edge T, out_valid at edge T+WORD_SIZE+2. busy is high in cycles T+1 .. T+WORD_SIZE+1.
- In the cycle where out_valid rises, busy is already 0, so a back-to-back accept is legal.
- out_valid is a one-cycle pulse per instruction. Outputs hold their value while out_valid=0.
- Flush in any state:
  - Next edge: IDLE, out_valid=0, busy=0.
  - No partial result is ever emitted.
  - flush wins over in_valid in the same cycle.
- in_valid while busy: ignored. The hazard unit holds ID/EX.
- rst has priority over flush and in_valid.
- zero for mul/div ops is computed on the final result.

Test Plan:
- ALU add, sel_forward1=1, mem_forward1=5, data1=99, data2=7, alu_src=0 -> one cycle later result=12, out_valid pulse, busy=0.
- DIV: rs1=-7, rs2=2 -> busy for 33 cycles; at T+34 result=0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1).
- DIVU x/0 with x=0x1234 -> result=0xFFFFFFFF. REMU x/0 -> 0x1234. DIV 0x80000000 / -1 -> 0x80000000. REM of the same operands -> 0, zero=1.
- MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU -1 * 0xFFFFFFFF -> 0xFFFFFFFF.
- Flush 10 cycles into a DIV -> next cycle busy=0, out_valid=0, no later out_valid. A subsequent ADD completes normally.
- Back-to-back MUL then ALU op:
  - The ALU op is presented the cycle out_valid rises -> accepted, out_valid the following cycle.
  - Forwarding inputs changed mid-iteration do not alter the MUL result.
  - rst asserted mid-ITER clears all outputs at the next edge.

Source files
------------

// File: rtl/ex_stage_md.sv
// Registered execute stage: forwarding muxes, single-cycle ALU and an iterative
// RV32M multiply/divide unit; also holds the EX/MEM pipeline register.
module ex_stage_md #(
   parameter int WORD_SIZE = 32,
   parameter int NUM_REGS  = 32,
   parameter int REG_SEL   = $clog2(NUM_REGS),
   parameter int ADDR_SIZE = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 flush,
   input  logic [ADDR_SIZE-1:0] pc,
   input  logic [WORD_SIZE-1:0] data1,
   input  logic [WORD_SIZE-1:0] wb_forward1,
   input  logic [WORD_SIZE-1:0] mem_forward1,
   input  logic [WORD_SIZE-1:0] data2,
   input  logic [WORD_SIZE-1:0] wb_forward2,
   input  logic [WORD_SIZE-1:0] mem_forward2,
   input  logic [1:0]           sel_forward1,
   input  logic [1:0]           sel_forward2,
   input  logic [WORD_SIZE-1:0] immd,
   input  logic [3:0]           alu_op,
   input  logic                 alu_src,
   input  logic                 md_en,
   input  logic [2:0]           md_op,
   input  logic [REG_SEL-1:0]   rd,
   input  logic [1:0]           data_size,
   input  logic                 data_sign,
   output logic                 busy,
   output logic                 out_valid,
   output logic [WORD_SIZE-1:0] result,
   output logic [WORD_SIZE-1:0] save_data,
   output logic                 zero,
   output logic [ADDR_SIZE-1:0] branch_target,
   output logic [REG_SEL-1:0]   rd_out,
   output logic [1:0]           data_size_out,
   output logic                 data_sign_out
);

   localparam int W     = WORD_SIZE;
   localparam int CNT_W = $clog2(WORD_SIZE);
   localparam int SH_W  = $clog2(WORD_SIZE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_SIZE - 1);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;
   localparam logic [3:0] ALU_PASS = 4'd10;

   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;

   typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

   state_t state_q, state_d;

   logic [W-1:0]         fwd1, fwd2, alu_b, alu_res;
   logic [SH_W-1:0]      shamt;
   logic [ADDR_SIZE-1:0] imm_addr, bt;
   logic                 accept;

   // Iterative unit state: hi/lo double as product (mul) or remainder/quotient (div)
   logic [W-1:0]         hi_q, lo_q, opnd_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [2:0]           md_op_q;
   logic                 sign1_q, sign2_q, dz_q;
   logic [W-1:0]         pend_save_q;
   logic [ADDR_SIZE-1:0] pend_bt_q;
   logic [REG_SEL-1:0]   pend_rd_q;
   logic [1:0]           pend_size_q;
   logic                 pend_sign_q;

   logic                 op1_signed, op2_signed, s1, s2;
   logic [W-1:0]         a_abs, b_abs;
   logic [W:0]           mul_sum, div_sh, div_diff;
   logic                 div_ok;
   logic [2*W-1:0]       prod, prod_fix;
   logic [W-1:0]         quo, rem, md_res;

   logic                 out_valid_q, zero_q, data_sign_q;
   logic [W-1:0]         result_q, save_data_q;
   logic [ADDR_SIZE-1:0] branch_target_q;
   logic [REG_SEL-1:0]   rd_q;
   logic [1:0]           data_size_q;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      fwd1 = data1;
      fwd2 = data2;
      case (sel_forward1)
         2'd1:    fwd1 = mem_forward1;
         2'd2:    fwd1 = wb_forward1;
         default: fwd1 = data1;
      endcase
      case (sel_forward2)
         2'd1:    fwd2 = mem_forward2;
         2'd2:    fwd2 = wb_forward2;
         default: fwd2 = data2;
      endcase
   end

   assign alu_b    = alu_src ? immd : fwd2;
   assign shamt    = alu_b[SH_W-1:0];
   assign imm_addr = ADDR_SIZE'({immd, 2'b00});
   assign bt       = pc + imm_addr;
   assign busy     = (state_q != IDLE);
   assign accept   = in_valid && !busy && !flush;

   always_comb begin
      alu_res = '0;
      case (alu_op)
         ALU_ADD:  alu_res = fwd1 + alu_b;
         ALU_SUB:  alu_res = fwd1 - alu_b;
         ALU_AND:  alu_res = fwd1 & alu_b;
         ALU_OR:   alu_res = fwd1 | alu_b;
         ALU_XOR:  alu_res = fwd1 ^ alu_b;
         ALU_SLL:  alu_res = fwd1 << shamt;
         ALU_SRL:  alu_res = fwd1 >> shamt;
         ALU_SRA:  alu_res = $signed(fwd1) >>> shamt;
         ALU_SLT:  alu_res = W'($signed(fwd1) < $signed(alu_b));
         ALU_SLTU: alu_res = W'(fwd1 < alu_b);
         ALU_PASS: alu_res = alu_b;
         default:  alu_res = '0;
      endcase
   end

   // Operand conditioning at capture: magnitudes plus sign flags
   assign op1_signed = (md_op != MD_MULHU) && (md_op != MD_DIVU) && (md_op != 3'd7);
   assign op2_signed = (md_op == MD_MUL) || (md_op == MD_MULH) ||
                       (md_op == MD_DIV) || (md_op == 3'd6);
   assign s1    = op1_signed && fwd1[W-1];
   assign s2    = op2_signed && fwd2[W-1];
   assign a_abs = s1 ? -fwd1 : fwd1;
   assign b_abs = s2 ? -fwd2 : fwd2;

   assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
   assign div_sh   = {hi_q, lo_q[W-1]};
   assign div_diff = div_sh - {1'b0, opnd_q};
   assign div_ok   = !div_diff[W];

   // Sign fix-up; the most-negative / -1 case falls out naturally (|q| = 2^(W-1), positive sign)
   assign prod     = {hi_q, lo_q};
   assign prod_fix = (sign1_q ^ sign2_q) ? -prod : prod;
   assign quo      = dz_q ? '1 : ((sign1_q ^ sign2_q) ? -lo_q : lo_q);
   assign rem      = sign1_q ? -hi_q : hi_q;

   always_comb begin
      md_res = rem;
      case (md_op_q)
         MD_MUL:                        md_res = prod_fix[W-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU:  md_res = prod_fix[2*W-1:W];
         MD_DIV, MD_DIVU:               md_res = quo;
         default:                       md_res = rem;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && md_en) state_d = ITER;
         ITER:    if (cnt_q == CNT_LAST) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: datapath registers carry no reset; they are always loaded at accept before use.
   always_ff @(posedge clk) begin
      if (accept && md_en) begin
         hi_q        <= '0;
         lo_q        <= md_op[2] ? a_abs : b_abs;
         opnd_q      <= md_op[2] ? b_abs : a_abs;
         cnt_q       <= '0;
         md_op_q     <= md_op;
         sign1_q     <= s1;
         sign2_q     <= s2;
         dz_q        <= (fwd2 == '0);
         pend_save_q <= fwd2;
         pend_bt_q   <= bt;
         pend_rd_q   <= rd;
         pend_size_q <= data_size;
         pend_sign_q <= data_sign;
      end else if (state_q == ITER) begin
         cnt_q <= cnt_q + 1'b1;
         if (md_op_q[2]) begin
            hi_q <= div_ok ? div_diff[W-1:0] : div_sh[W-1:0];
            lo_q <= {lo_q[W-2:0], div_ok};
         end else begin
            hi_q <= mul_sum[W:1];
            lo_q <= {mul_sum[0], lo_q[W-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         out_valid_q     <= 1'b0;
         result_q        <= '0;
         zero_q          <= 1'b0;
         save_data_q     <= '0;
         branch_target_q <= '0;
         rd_q            <= '0;
         data_size_q     <= '0;
         data_sign_q     <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (accept && !md_en) begin
            out_valid_q     <= 1'b1;
            result_q        <= alu_res;
            zero_q          <= (alu_res == '0);
            save_data_q     <= fwd2;
            branch_target_q <= bt;
            rd_q            <= rd;
            data_size_q     <= data_size;
            data_sign_q     <= data_sign;
         end else if (state_q == FIX) begin
            out_valid_q     <= 1'b1;
            result_q        <= md_res;
            zero_q          <= (md_res == '0);
            save_data_q     <= pend_save_q;
            branch_target_q <= pend_bt_q;
            rd_q            <= pend_rd_q;
            data_size_q     <= pend_size_q;
            data_sign_q     <= pend_sign_q;
         end
      end
   end

   assign out_valid     = out_valid_q;
   assign result        = result_q;
   assign zero          = zero_q;
   assign save_data     = save_data_q;
   assign branch_target = branch_target_q;
   assign rd_out        = rd_q;
   assign data_size_out = data_size_q;
   assign data_sign_out = data_sign_q;

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: ALU path, mul/div corner cases, flush, reset
// and back-to-back issue, with hand-computed expectations.
module tb_ex_stage_md;

   localparam int W  = 32;
   localparam int RS = 5;
   localparam int AS = 10;

   localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
   localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

   logic          clk = 1'b0;
   logic          rst, in_valid, flush, alu_src, md_en, data_sign;
   logic [AS-1:0] pc;
   logic [W-1:0]  data1, wb_forward1, mem_forward1, data2, wb_forward2, mem_forward2, immd;
   logic [1:0]    sel_forward1, sel_forward2, data_size;
   logic [3:0]    alu_op;
   logic [2:0]    md_op;
   logic [RS-1:0] rd;
   logic          busy, out_valid, zero, data_sign_out;
   logic [W-1:0]  result, save_data;
   logic [AS-1:0] branch_target;
   logic [RS-1:0] rd_out;
   logic [1:0]    data_size_out;

   int checks = 0;
   int errors = 0;
   int nbusy;
   int seen;

   ex_stage_md dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .pc(pc),
      .data1(data1), .wb_forward1(wb_forward1), .mem_forward1(mem_forward1),
      .data2(data2), .wb_forward2(wb_forward2), .mem_forward2(mem_forward2),
      .sel_forward1(sel_forward1), .sel_forward2(sel_forward2), .immd(immd),
      .alu_op(alu_op), .alu_src(alu_src), .md_en(md_en), .md_op(md_op), .rd(rd),
      .data_size(data_size), .data_sign(data_sign), .busy(busy), .out_valid(out_valid),
      .result(result), .save_data(save_data), .zero(zero), .branch_target(branch_target),
      .rd_out(rd_out), .data_size_out(data_size_out), .data_sign_out(data_sign_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic defaults();
      in_valid = 1'b0; flush = 1'b0; md_en = 1'b0; md_op = 3'd0;
      sel_forward1 = 2'd0; sel_forward2 = 2'd0; alu_op = 4'd0; alu_src = 1'b0;
      data1 = '0; data2 = '0; wb_forward1 = '0; wb_forward2 = '0;
      mem_forward1 = '0; mem_forward2 = '0; immd = '0; pc = '0;
      rd = '0; data_size = 2'd0; data_sign = 1'b0;
   endtask

   // immd/alu_src are set so that wrongly using the immediate would change the result
   task automatic issue_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [RS-1:0] rd_v);
      in_valid = 1'b1; md_en = 1'b1; md_op = op; alu_src = 1'b1; immd = 32'd5;
      sel_forward1 = 2'd0; sel_forward2 = 2'd0; data1 = a; data2 = b;
      pc = 10'd100; rd = rd_v; data_size = 2'd1; data_sign = 1'b1;
      tick();
      in_valid = 1'b0; md_en = 1'b0; alu_src = 1'b0;
   endtask

   // Scrambles the forwarding inputs while waiting, bounded to 40 cycles
   task automatic wait_done(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid === 1'b1) break;
         if (busy === 1'b1) n++;
         data1 = $urandom; data2 = $urandom;
         mem_forward1 = $urandom; mem_forward2 = $urandom;
         wb_forward1 = $urandom; wb_forward2 = $urandom;
         tick();
      end
   endtask

   task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int n;
      issue_md(op, a, b, 5'd9);
      wait_done(n);
      check({tag, "/busy_cycles"}, 32'(n), 32'd33);
      check({tag, "/out_valid"}, 32'(out_valid), 32'd1);
      check({tag, "/busy_low"}, 32'(busy), 32'd0);
      check({tag, "/result"}, result, exp);
      check({tag, "/zero"}, 32'(zero), 32'(exp == 32'd0));
   endtask

   initial begin
      defaults();
      // reset has priority over a valid ALU op
      rst = 1'b1; in_valid = 1'b1; data1 = 32'd1; data2 = 32'd1; rd = 5'd7;
      tick(); tick();
      check("rst/busy", 32'(busy), 32'd0);
      check("rst/out_valid", 32'(out_valid), 32'd0);
      check("rst/result", result, 32'd0);
      check("rst/rd_out", 32'(rd_out), 32'd0);
      check("rst/zero", 32'(zero), 32'd0);
      rst = 1'b0; defaults(); tick();

      // ADD with mem forwarding on rs1
      in_valid = 1'b1; sel_forward1 = 2'd1; mem_forward1 = 32'd5; data1 = 32'd99; data2 = 32'd7;
      alu_op = 4'd0; rd = 5'd3; data_size = 2'd2; data_sign = 1'b1; pc = 10'd10; immd = 32'd4;
      tick();
      check("add/out_valid", 32'(out_valid), 32'd1);
      check("add/busy", 32'(busy), 32'd0);
      check("add/result", result, 32'd12);
      check("add/zero", 32'(zero), 32'd0);
      check("add/save_data", save_data, 32'd7);
      check("add/branch_target", 32'(branch_target), 32'd26);
      check("add/rd_out", 32'(rd_out), 32'd3);
      check("add/data_size", 32'(data_size_out), 32'd2);
      check("add/data_sign", 32'(data_sign_out), 32'd1);
      defaults(); tick();
      check("add/pulse_end", 32'(out_valid), 32'd0);
      check("add/hold", result, 32'd12);

      // SUB with wb forward on rs1 and mem forward on rs2 -> zero
      in_valid = 1'b1; alu_op = 4'd1; sel_forward1 = 2'd2; wb_forward1 = 32'd20;
      sel_forward2 = 2'd1; mem_forward2 = 32'd20; data1 = 32'd3; data2 = 32'd4;
      tick();
      check("sub/result", result, 32'd0);
      check("sub/zero", 32'(zero), 32'd1);
      check("sub/save_data", save_data, 32'd20);
      // ADD immediate, select 3 means data1
      defaults(); in_valid = 1'b1; sel_forward1 = 2'd3; data1 = 32'd100; data2 = 32'd7;
      immd = 32'd5; alu_src = 1'b1;
      tick();
      check("addi/result", result, 32'd105);
      check("addi/save_data", save_data, 32'd7);
      defaults(); tick();

      run_md("div", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      check("div/rd_out", 32'(rd_out), 32'd9);
      check("div/branch_target", 32'(branch_target), 32'd120);
      check("div/save_data", save_data, 32'd2);
      check("div/data_size", 32'(data_size_out), 32'd1);
      tick();
      check("div/pulse_end", 32'(out_valid), 32'd0);
      run_md("rem", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      run_md("divu_by0", DIVU, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
      run_md("remu_by0", REMU, 32'h0000_1234, 32'd0, 32'h0000_1234);
      run_md("div_by0_neg", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
      run_md("rem_by0_neg", REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
      run_md("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_md("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      run_md("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      run_md("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_md("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_md("mul", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
      defaults(); tick();

      // flush 10 cycles into a DIV; the ALU op presented alongside is killed too
      issue_md(DIV, 32'hFFFF_FFF9, 32'd2, 5'd4);
      repeat (10) tick();
      flush = 1'b1; in_valid = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush/busy", 32'(busy), 32'd0);
      check("flush/out_valid", 32'(out_valid), 32'd0);
      check("flush/result", result, 32'd0);
      seen = 0;
      repeat (40) begin
         tick();
         if (out_valid !== 1'b0) seen++;
      end
      check("flush/no_late_valid", 32'(seen), 32'd0);
      in_valid = 1'b1; data1 = 32'd1; data2 = 32'd2; alu_op = 4'd0;
      tick();
      check("flush/add_after", result, 32'd3);
      check("flush/add_valid", 32'(out_valid), 32'd1);
      // flush beats in_valid in IDLE
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_vs_valid/out_valid", 32'(out_valid), 32'd0);
      check("flush_vs_valid/result", result, 32'd0);

      // MUL with an ALU op held on in_valid throughout; accepted only once busy drops
      defaults();
      issue_md(MUL, 32'd6, 32'd7, 5'd2);
      in_valid = 1'b1; alu_op = 4'd0;
      wait_done(nbusy);
      check("b2b/busy_cycles", 32'(nbusy), 32'd33);
      check("b2b/mul_result", result, 32'd42);
      check("b2b/mul_valid", 32'(out_valid), 32'd1);
      sel_forward1 = 2'd0; sel_forward2 = 2'd0; data1 = 32'd8; data2 = 32'd9; rd = 5'd6;
      tick();
      in_valid = 1'b0;
      check("b2b/alu_valid", 32'(out_valid), 32'd1);
      check("b2b/alu_result", result, 32'd17);
      check("b2b/alu_rd", 32'(rd_out), 32'd6);
      check("b2b/busy", 32'(busy), 32'd0);

      // reset in the middle of an iteration
      issue_md(MUL, 32'd3, 32'd3, 5'd1);
      repeat (5) tick();
      check("rst_mid/busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid/busy", 32'(busy), 32'd0);
      check("rst_mid/out_valid", 32'(out_valid), 32'd0);
      check("rst_mid/result", result, 32'd0);
      check("rst_mid/rd_out", 32'(rd_out), 32'd0);
      check("rst_mid/save_data", save_data, 32'd0);
      seen = 0;
      repeat (40) begin
         tick();
         if (out_valid !== 1'b0) seen++;
      end
      check("rst_mid/no_late_valid", 32'(seen), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
